// File: rtl/tof_result_buf.sv
// Per-frame buffer for time-of-flight results: collects up to DEPTH valid hits
// between a laser trigger and the window end, then drains them oldest first.
module tof_result_buf #(
  parameter int DW    = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tri_en,
  input  logic          frame_end,
  input  logic          tof_valid,
  input  logic [DW-1:0] tof_data,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic [2:0]    hit_cnt,
  output logic [DW-1:0] min_tof,
  output logic          overflow,
  output logic          busy
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] INVALID = {DW{1'b1}};
  localparam logic [2:0]    DEPTH_C = 3'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state_r;
  logic [DW-1:0] mem_r [DEPTH];
  logic [2:0]    rd_ptr_r;
  logic [2:0]    hit_cnt_r;
  logic [DW-1:0] min_tof_r;
  logic          overflow_r;
  logic          busy_r;
  logic          rd_valid_r;
  logic          rd_last_r;
  logic [DW-1:0] rd_data_r;

  logic          accept_s;
  logic          store_s;
  logic          ovf_s;
  logic [2:0]    hit_next_s;
  logic [2:0]    rd_ptr_next_s;
  logic [DW-1:0] first_word_s;

  // Sample qualification; a restart on the same cycle discards the sample.
  always_comb begin
    accept_s      = 1'b0;
    store_s       = 1'b0;
    ovf_s         = 1'b0;
    first_word_s  = mem_r[0];
    if (state_r == COLLECT && !tri_en && tof_valid && tof_data != INVALID) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s && hit_cnt_r < DEPTH_C) begin
      store_s = 1'b1;
    end else begin
      ovf_s   = accept_s;
    end
    if (store_s && hit_cnt_r == 3'd0) begin
      first_word_s = tof_data;
    end else begin
      first_word_s = mem_r[0];
    end
    hit_next_s    = hit_cnt_r + {2'b00, store_s};
    rd_ptr_next_s = rd_ptr_r + 3'd1;
  end

  // Result storage, written at the current hit count; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[hit_cnt_r[AW-1:0]] <= tof_data;
    end
  end

  // Frame control FSM with registered read port and frame statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      rd_ptr_r   <= 3'd0;
      hit_cnt_r  <= 3'd0;
      min_tof_r  <= INVALID;
      overflow_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (tri_en) begin
            state_r    <= COLLECT;
            busy_r     <= 1'b1;
            hit_cnt_r  <= 3'd0;
            min_tof_r  <= INVALID;
            overflow_r <= 1'b0;
          end
        end
        COLLECT: begin
          if (tri_en) begin
            hit_cnt_r  <= 3'd0;
            min_tof_r  <= INVALID;
            overflow_r <= 1'b0;
          end else begin
            hit_cnt_r <= hit_next_s;
            if (store_s && tof_data < min_tof_r) begin
              min_tof_r <= tof_data;
            end
            if (ovf_s) begin
              overflow_r <= 1'b1;
            end
            // Window close: preload the first word so it is visible in the first DRAIN cycle.
            if (frame_end) begin
              state_r    <= DRAIN;
              rd_valid_r <= 1'b1;
              rd_ptr_r   <= 3'd0;
              rd_data_r  <= (hit_next_s == 3'd0) ? INVALID : first_word_s;
              rd_last_r  <= (hit_next_s <= 3'd1);
            end
          end
        end
        DRAIN: begin
          if (rd_ready) begin
            if (rd_last_r) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              rd_valid_r <= 1'b0;
              rd_last_r  <= 1'b0;
            end else begin
              rd_ptr_r  <= rd_ptr_next_s;
              rd_data_r <= mem_r[rd_ptr_next_s[AW-1:0]];
              rd_last_r <= (rd_ptr_next_s == hit_cnt_r - 3'd1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_last  = rd_last_r;
  assign hit_cnt  = hit_cnt_r;
  assign min_tof  = min_tof_r;
  assign overflow = overflow_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_tof_result_buf.sv
// Bench for tof_result_buf: directed frame table, multi-cycle corner cases and
// randomized frames checked against a queue-based reference model.
module tb_tof_result_buf;

  localparam logic [14:0] INV = 15'h7FFF;

  logic        clk = 1'b0;
  logic        rst_n, tri_en, frame_end, tof_valid, rd_ready;
  logic [14:0] tof_data;
  logic        rd_valid, rd_last, overflow, busy;
  logic [14:0] rd_data, min_tof;
  logic [2:0]  hit_cnt;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  logic [14:0] mdl_q[$];
  bit          mdl_ovf;

  tof_result_buf #(.DW(15), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tri_en(tri_en), .frame_end(frame_end),
    .tof_valid(tof_valid), .tof_data(tof_data), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .hit_cnt(hit_cnt), .min_tof(min_tof), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [5:0][14:0] v;
    int               exp_hits;
    logic [14:0]      exp_min;
    bit               exp_ovf;
    int               exp_nrd;
    logic [3:0][14:0] exp_rd;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    tri_en = 1'b1;
    step();
    tri_en = 1'b0;
  endtask

  task automatic send(input logic [14:0] v);
    tof_valid = 1'b1;
    tof_data  = v;
    step();
    tof_valid = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  // Drains exp_q; rd_data must match the head every cycle, so stalls also check holding.
  task automatic drain_check(input bit rnd_ready, input bit noise, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      rd_ready  = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tri_en    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      tof_valid = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      tof_data  = 15'($urandom_range(0, 1000));
      chk("drain_valid", int'(rd_valid), 1);
      chk("drain_data", int'(rd_data), int'(exp_q[0]));
      chk("drain_last", int'(rd_last), (exp_q.size() == 1) ? 1 : 0);
      if (rd_ready) void'(exp_q.pop_front());
      step();
      cycles++;
    end
    rd_ready = 1'b0; tri_en = 1'b0; tof_valid = 1'b0;
    chk("drain_done_in_budget", (exp_q.size() == 0) ? 1 : 0, 1);
    exp_q.delete();
    chk("post_drain_valid", int'(rd_valid), 0);
    chk("post_drain_busy", int'(busy), 0);
  endtask

  function automatic logic [14:0] mdl_min();
    logic [14:0] m = INV;
    foreach (mdl_q[i]) if (mdl_q[i] < m) m = mdl_q[i];
    return m;
  endfunction

  function automatic void mdl_sample(input logic [14:0] v);
    if (v != INV) begin
      if (mdl_q.size() < 4) mdl_q.push_back(v);
      else mdl_ovf = 1'b1;
    end
  endfunction

  task automatic check_stats(input string tag, input int h, input int m, input int o);
    chk({tag, "_hit_cnt"}, int'(hit_cnt), h);
    chk({tag, "_min_tof"}, int'(min_tof), m);
    chk({tag, "_overflow"}, int'(overflow), o);
  endtask

  initial begin
    int cyc;
    int nv;
    rst_n = 1'b0; tri_en = 1'b0; frame_end = 1'b0; tof_valid = 1'b0;
    tof_data = 15'd0; rd_ready = 1'b0;

    vecs[0].n = 4; vecs[0].v[0] = 15'd100; vecs[0].v[1] = 15'd40; vecs[0].v[2] = INV; vecs[0].v[3] = 15'd300;
    vecs[0].exp_hits = 3; vecs[0].exp_min = 15'd40; vecs[0].exp_ovf = 1'b0; vecs[0].exp_nrd = 3;
    vecs[0].exp_rd[0] = 15'd100; vecs[0].exp_rd[1] = 15'd40; vecs[0].exp_rd[2] = 15'd300;
    vecs[1].n = 6;
    for (int i = 0; i < 6; i++) vecs[1].v[i] = 15'(10 + i);
    vecs[1].exp_hits = 4; vecs[1].exp_min = 15'd10; vecs[1].exp_ovf = 1'b1; vecs[1].exp_nrd = 4;
    for (int i = 0; i < 4; i++) vecs[1].exp_rd[i] = 15'(10 + i);
    vecs[2].n = 0; vecs[2].exp_hits = 0; vecs[2].exp_min = INV; vecs[2].exp_ovf = 1'b0;
    vecs[2].exp_nrd = 1; vecs[2].exp_rd[0] = INV;
    vecs[3].n = 3; vecs[3].v[0] = INV; vecs[3].v[1] = 15'd500; vecs[3].v[2] = 15'd0;
    vecs[3].exp_hits = 2; vecs[3].exp_min = 15'd0; vecs[3].exp_ovf = 1'b0; vecs[3].exp_nrd = 2;
    vecs[3].exp_rd[0] = 15'd500; vecs[3].exp_rd[1] = 15'd0;

    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_last", int'(rd_last), 0);
    check_stats("rst", 0, int'(INV), 0);
    rst_n = 1'b1;
    step();

    // Directed frame table
    foreach (vecs[k]) begin
      start_frame();
      chk("tbl_busy_collect", int'(busy), 1);
      for (int i = 0; i < vecs[k].n; i++) send(vecs[k].v[i]);
      end_frame();
      check_stats("tbl", vecs[k].exp_hits, int'(vecs[k].exp_min), int'(vecs[k].exp_ovf));
      for (int i = 0; i < vecs[k].exp_nrd; i++) exp_q.push_back(vecs[k].exp_rd[i]);
      drain_check(1'b0, 1'b0, cyc);
      chk("tbl_drain_cycles", cyc, vecs[k].exp_nrd);
      step();
      check_stats("tbl_idle_hold", vecs[k].exp_hits, int'(vecs[k].exp_min), int'(vecs[k].exp_ovf));
    end

    // Stall pattern 1,0,0,1 plus ignored tri_en/tof_valid during DRAIN
    start_frame(); send(15'd7); send(15'd8); end_frame();
    rd_ready = 1'b1; step();
    rd_ready = 1'b0; tri_en = 1'b1; tof_valid = 1'b1; tof_data = 15'd1;
    step();
    chk("stall_data_1", int'(rd_data), 8);
    step();
    chk("stall_data_2", int'(rd_data), 8);
    chk("stall_last", int'(rd_last), 1);
    tri_en = 1'b0; tof_valid = 1'b0;
    check_stats("stall_ignored", 2, 7, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("stall_idle_valid", int'(rd_valid), 0);
    chk("stall_idle_busy", int'(busy), 0);

    // Sample coincident with frame_end is stored and drained last
    start_frame(); send(15'd60);
    tof_valid = 1'b1; tof_data = 15'd55; frame_end = 1'b1;
    step();
    tof_valid = 1'b0; frame_end = 1'b0;
    check_stats("coinc", 2, 55, 0);
    exp_q.push_back(15'd60); exp_q.push_back(15'd55);
    drain_check(1'b0, 1'b0, cyc);

    // tri_en with frame_end restarts the frame and stays in COLLECT
    start_frame(); send(15'd5);
    tri_en = 1'b1; frame_end = 1'b1;
    step();
    tri_en = 1'b0; frame_end = 1'b0;
    chk("restart_busy", int'(busy), 1);
    chk("restart_rd_valid", int'(rd_valid), 0);
    check_stats("restart", 0, int'(INV), 0);
    send(15'd9); end_frame();
    exp_q.push_back(15'd9);
    drain_check(1'b0, 1'b0, cyc);

    // Asynchronous reset during DRAIN after one transfer
    start_frame(); send(15'd1); send(15'd2); send(15'd3); end_frame();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", int'(rd_valid), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_rd_last", int'(rd_last), 0);
    chk("arst_busy", int'(busy), 0);
    check_stats("arst", 0, int'(INV), 0);
    step();
    rst_n = 1'b1;
    start_frame(); send(15'd21); send(15'd20); end_frame();
    check_stats("post_rst", 2, 20, 0);
    exp_q.push_back(15'd21); exp_q.push_back(15'd20);
    drain_check(1'b0, 1'b0, cyc);

    // Randomized frames against the queue model
    for (int f = 0; f < 40; f++) begin
      mdl_q.delete(); mdl_ovf = 1'b0;
      start_frame();
      nv = $urandom_range(0, 7);
      for (int i = 0; i < nv; i++) begin
        repeat ($urandom_range(0, 2)) step();
        tof_valid = 1'b1;
        tof_data  = ($urandom_range(0, 5) == 0) ? INV : 15'($urandom_range(0, 32766));
        mdl_sample(tof_data);
        if (i == nv - 1 && $urandom_range(0, 1) == 1) frame_end = 1'b1;
        step();
        tof_valid = 1'b0;
      end
      if (!frame_end) begin
        frame_end = 1'b1;
        step();
      end
      frame_end = 1'b0;
      check_stats("rnd", mdl_q.size(), int'(mdl_min()), int'(mdl_ovf));
      if (mdl_q.size() == 0) exp_q.push_back(INV);
      else foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      drain_check(1'b1, 1'b1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tof_result_buf.md
TOF_RESULT_BUF -- requirements
Module: tof_result_buf

Interface
REQ-001 Parameter: DW, 15, TOF word width; 15'h7FFF (all ones) is the invalid/out-of-range marker.
REQ-002 Parameter: DEPTH, 4, max stored TOF results per frame.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tri_en  input  1  frame-start pulse (laser trigger), one cycle.
REQ-006 frame_end  input  1  end-of-measurement-window pulse, one cycle.
REQ-007 tof_valid  input  1  one-cycle result strobe from TOF calculation stage.
REQ-008 tof_data  input  DW  TOF result; valid only when tof_valid=1.
REQ-009 rd_ready  input  1  downstream accepts rd_data this cycle.
REQ-010 rd_valid  output  1  rd_data holds a buffered result.
REQ-011 rd_data  output  DW  buffered TOF result, oldest first.
REQ-012 rd_last  output  1  qualifies rd_valid: final word of frame.
REQ-013 hit_cnt  output  3  valid results stored in current/last frame (0..DEPTH).
REQ-014 min_tof  output  DW  smallest stored result of frame; 15'h7FFF if none.
REQ-015 overflow  output  1  sticky per frame: valid result arrived while full.
REQ-016 busy  output  1  high in COLLECT or DRAIN.

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, DRAIN; busy=1 when state != IDLE.
REQ-018 IDLE: tri_en -> COLLECT next cycle; same edge clears write pointer, hit_cnt=0, overflow=0, min_tof=7FFF.
REQ-019 COLLECT: tof_valid with tof_data != 7FFF and hit_cnt<DEPTH SHALL write entry[hit_cnt], increment hit_cnt on same edge.
REQ-020 COLLECT: tof_valid with tof_data == 7FFF SHALL be discarded; no counter or flag change.
REQ-021 COLLECT: valid tof_data with hit_cnt==DEPTH SHALL be discarded, overflow set to 1 (held until next frame start).
REQ-022 min_tof SHALL update to tof_data on each stored write where tof_data < min_tof (unsigned compare), same edge as write.
REQ-023 COLLECT: frame_end -> DRAIN; if tof_valid coincides, the sample SHALL be processed (REQ-019..022) before transition.
REQ-024 COLLECT: tri_en SHALL restart the frame (REQ-018 clears), stay COLLECT; tri_en+frame_end same cycle: restart wins.
REQ-025 tof_valid in IDLE or DRAIN SHALL be ignored; tri_en in DRAIN SHALL be ignored.
REQ-026 DRAIN: rd_valid=1 from first DRAIN cycle; rd_data=entry[rd_ptr], rd_ptr starts 0.
REQ-027 Transfer occurs on rd_valid&rd_ready; rd_ptr increments; rd_data/rd_valid SHALL hold stable while rd_ready=0.
REQ-028 rd_last=1 when rd_ptr==hit_cnt-1; transfer with rd_last -> IDLE, rd_valid=0 next cycle.
REQ-029 DRAIN with hit_cnt==0 SHALL present one word rd_data=7FFF, rd_last=1 (no-target marker), then IDLE after transfer.
REQ-030 Throughput: one word per cycle when rd_ready held high; frame of N hits drains in max(N,1) cycles.
REQ-031 hit_cnt, min_tof, overflow SHALL remain valid in IDLE until next tri_en.
REQ-032 rd_data SHALL be registered; rd_valid/rd_last registered or decoded from registered state only (no input-to-output comb path).

Reset
REQ-033 rst_n low SHALL force state IDLE, rd_valid=0, rd_last=0, rd_data=0, hit_cnt=0, min_tof=7FFF, overflow=0, busy=0, pointers 0, immediately.
REQ-034 Reset mid-COLLECT or mid-DRAIN SHALL discard the frame; storage contents need not clear.

Verification
REQ-035 tri_en; tof 100, 40, 7FFF, 300; frame_end; rd_ready=1 -> reads 100,40,300, rd_last on 300, hit_cnt=3, min_tof=40, overflow=0.
REQ-036 tri_en; six valid results 10..15; frame_end -> hit_cnt=4, reads 10..13, overflow=1, min_tof=10.
REQ-037 tri_en; frame_end with no results -> single word 7FFF with rd_last=1, hit_cnt=0, then IDLE.
REQ-038 Drain with rd_ready toggled 1,0,0,1 -> rd_data held while stalled, no duplicated or lost words; tri_en and tof_valid during DRAIN ignored.
REQ-039 tof_valid(55)+frame_end same cycle -> 55 stored and drained last; tri_en+frame_end same cycle -> frame restart, stays COLLECT.
REQ-040 Assert rst_n low during DRAIN after one transfer -> all outputs at REQ-033 values next edge; new frame then operates normally.
